// File: rtl/lc_ctrl_pkg.sv
// rtl/lc_ctrl_pkg.sv - shared life cycle word counts and programming FSM encoding
package lc_ctrl_pkg;

  localparam int NumLcCntWords   = 24;
  localparam int NumLcStateWords = 20;
  localparam int NumLcWords      = NumLcCntWords + NumLcStateWords;
  localparam int LcWordIdxWidth  = 6;
  localparam int LcAddrWidth     = 10;

  // Codes form a [6,3] linear code: every pair differs in at least 3 bits,
  // and the all-zero pattern (a stuck-low register) lands in the error state.
  typedef enum logic [5:0] {
    st_idle         = 6'b001011,
    st_check        = 6'b010101,
    st_scan         = 6'b011110,
    st_write        = 6'b100110,
    st_wait_done    = 6'b101101,
    st_ack          = 6'b110011,
    st_wait_req_low = 6'b111000,
    st_error        = 6'b000000
  } lc_otp_prog_fsm_e;

endpackage

// File: rtl/lc_otp_word_sel.sv
// rtl/lc_otp_word_sel.sv - selects one 16-bit word of target/current and flags a difference
module lc_otp_word_sel
  import lc_ctrl_pkg::*;
#(
  parameter int WordWidth  = 16,
  parameter int TotalWidth = 704
) (
  input  logic [TotalWidth-1:0]     target,
  input  logic [TotalWidth-1:0]     current,
  input  logic [LcWordIdxWidth-1:0] idx,
  output logic [WordWidth-1:0]      tgt_word,
  output logic                      diff
);

  localparam int OffWidth = $clog2(TotalWidth);

  logic                in_range;
  logic [OffWidth-1:0] offset;
  logic [WordWidth-1:0] cur_word;

  // Out-of-range indices select word 0 and never report a difference.
  assign in_range = idx < LcWordIdxWidth'(NumLcWords);
  assign offset   = in_range ? OffWidth'(idx) * OffWidth'(WordWidth) : '0;
  assign tgt_word = target[offset +: WordWidth];
  assign cur_word = current[offset +: WordWidth];
  assign diff     = in_range && (tgt_word != cur_word);

endmodule

// File: rtl/lc_otp_prog_responder.sv
// rtl/lc_otp_prog_responder.sv - OTP-side responder writing changed life cycle words to the macro
module lc_otp_prog_responder
  import lc_ctrl_pkg::*;
#(
  parameter int LcStateWidth = 320,
  parameter int LcCountWidth = 384,
  parameter int WordWidth    = 16,
  parameter int BaseAddr     = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    prog_req_i,
  input  logic [LcStateWidth-1:0] prog_state_i,
  input  logic [LcCountWidth-1:0] prog_cnt_i,
  output logic                    prog_ack_o,
  output logic                    prog_err_o,
  input  logic [LcStateWidth-1:0] cur_state_i,
  input  logic [LcCountWidth-1:0] cur_cnt_i,
  output logic                    wr_req_o,
  output logic [LcAddrWidth-1:0]  wr_addr_o,
  output logic [WordWidth-1:0]    wr_data_o,
  input  logic                    wr_gnt_i,
  input  logic                    wr_done_i,
  input  logic                    wr_err_i,
  output logic                    busy_o
);

  localparam int TotalWidth = LcCountWidth + LcStateWidth;
  localparam logic [LcWordIdxWidth-1:0] LastIdx = LcWordIdxWidth'(NumLcWords - 1);
  localparam logic [LcWordIdxWidth-1:0] EndIdx  = LcWordIdxWidth'(NumLcWords);

  lc_otp_prog_fsm_e            state_q, state_d;
  logic [LcWordIdxWidth-1:0]   idx_q, idx_d;
  logic                        err_q, err_d;
  logic                        err_ack_q, err_ack_d;
  logic [TotalWidth-1:0]       target_q, current_q;
  logic                        capture;
  logic                        illegal;
  logic                        word_diff;
  logic [WordWidth-1:0]        word_data;

  lc_otp_word_sel #(
    .WordWidth  (WordWidth),
    .TotalWidth (TotalWidth)
  ) u_word_sel (
    .target   (target_q),
    .current  (current_q),
    .idx      (idx_q),
    .tgt_word (word_data),
    .diff     (word_diff)
  );

  // OTP bits can only be set; any bit stored as 1 but targeted as 0 is a clear attempt.
  assign illegal = |(current_q & ~target_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= st_idle;
      idx_q     <= '0;
      err_q     <= 1'b0;
      err_ack_q <= 1'b0;
      target_q  <= '0;
      current_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      err_ack_q <= err_ack_d;
      if (capture) begin
        target_q  <= {prog_state_i, prog_cnt_i};
        current_q <= {cur_state_i, cur_cnt_i};
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    err_d      = err_q;
    err_ack_d  = err_ack_q;
    capture    = 1'b0;
    wr_req_o   = 1'b0;
    prog_ack_o = 1'b0;
    prog_err_o = 1'b0;
    busy_o     = 1'b1;
    case (state_q)
      st_idle: begin
        busy_o = 1'b0;
        if (prog_req_i) begin
          capture = 1'b1;
          err_d   = 1'b0;
          state_d = st_check;
        end
      end
      st_check: begin
        if (illegal) begin
          err_d   = 1'b1;
          state_d = st_ack;
        end else begin
          idx_d   = '0;
          state_d = st_scan;
        end
      end
      st_scan: begin
        if (idx_q >= EndIdx) begin
          state_d = st_ack;
        end else if (word_diff) begin
          state_d = st_write;
        end else if (idx_q == LastIdx) begin
          state_d = st_ack;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      st_write: begin
        wr_req_o = 1'b1;
        if (wr_gnt_i) begin
          state_d = st_wait_done;
        end
      end
      st_wait_done: begin
        if (wr_done_i) begin
          if (wr_err_i) begin
            err_d   = 1'b1;
            state_d = st_ack;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = st_scan;
          end
        end
      end
      st_ack: begin
        prog_ack_o = 1'b1;
        prog_err_o = err_q;
        state_d    = st_wait_req_low;
      end
      st_wait_req_low: begin
        if (!prog_req_i) begin
          state_d = st_idle;
        end
      end
      st_error: begin
        // Terminal: answer each request once with an error, re-arm when it drops.
        if (prog_req_i && !err_ack_q) begin
          prog_ack_o = 1'b1;
          prog_err_o = 1'b1;
          err_ack_d  = 1'b1;
        end else if (!prog_req_i) begin
          err_ack_d = 1'b0;
        end
      end
      default: begin
        state_d = st_error;
      end
    endcase
  end

  assign wr_addr_o = wr_req_o ? LcAddrWidth'(BaseAddr) + LcAddrWidth'(idx_q) : '0;
  assign wr_data_o = wr_req_o ? word_data : '0;

endmodule

// File: tb/tb_lc_otp_prog_responder.sv
// tb/tb_lc_otp_prog_responder.sv - randomized self-checking bench with word-diff reference model
module tb_lc_otp_prog_responder;
  import lc_ctrl_pkg::*;

  localparam int SW = 320;
  localparam int CW = 384;
  localparam int TW = SW + CW;
  localparam int WW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          prog_req_i;
  logic [SW-1:0] prog_state_i;
  logic [CW-1:0] prog_cnt_i;
  logic          prog_ack_o;
  logic          prog_err_o;
  logic [SW-1:0] cur_state_i;
  logic [CW-1:0] cur_cnt_i;
  logic          wr_req_o;
  logic [9:0]    wr_addr_o;
  logic [WW-1:0] wr_data_o;
  logic          wr_gnt_i;
  logic          wr_done_i;
  logic          wr_err_i;
  logic          busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  lc_otp_prog_responder dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .prog_req_i   (prog_req_i),
    .prog_state_i (prog_state_i),
    .prog_cnt_i   (prog_cnt_i),
    .prog_ack_o   (prog_ack_o),
    .prog_err_o   (prog_err_o),
    .cur_state_i  (cur_state_i),
    .cur_cnt_i    (cur_cnt_i),
    .wr_req_o     (wr_req_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .wr_gnt_i     (wr_gnt_i),
    .wr_done_i    (wr_done_i),
    .wr_err_i     (wr_err_i),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] make_base();
    logic [TW-1:0] v;
    v = '0;
    for (int w = 0; w < NumLcWords; w++) v[w*WW +: WW] = 16'($urandom) & 16'h7fff;
    return v;
  endfunction

  function automatic logic [TW-1:0] bump(input logic [TW-1:0] v, input int w);
    logic [TW-1:0] r;
    r = v;
    r[w*WW +: WW] = r[w*WW +: WW] | 16'h8000 | 16'($urandom);
    return r;
  endfunction

  // Reference: illegal if any stored 1 is targeted as 0; otherwise each differing
  // word in ascending order is written, stopping after the write the macro fails.
  task automatic run_txn(input logic [TW-1:0] cur, input logic [TW-1:0] tgt,
                         input int fail_idx, input int gnt_fix, input bit rst_mid);
    int          exp_addr[$];
    logic [15:0] exp_data[$];
    int          obs_addr[$];
    logic [15:0] obs_data[$];
    bit          illegal, exp_err, ack_seen, ack_err, done;
    int          exp_lat, phase, gnt_wait, done_wait, cyc, ack_cyc, post, n;
    logic [9:0]  hold_addr;
    logic [15:0] hold_data;

    illegal = |(cur & ~tgt);
    exp_err = illegal;
    if (!illegal) begin
      for (int w = 0; w < NumLcWords; w++) begin
        if (tgt[w*WW +: WW] != cur[w*WW +: WW]) begin
          exp_addr.push_back(w);
          exp_data.push_back(tgt[w*WW +: WW]);
          if (exp_addr.size() - 1 == fail_idx) begin
            exp_err = 1'b1;
            break;
          end
        end
      end
    end
    exp_lat = -1;
    if (illegal) exp_lat = 2;
    else if (exp_addr.size() == 0) exp_lat = 2 + NumLcWords;

    {prog_state_i, prog_cnt_i} = tgt;
    {cur_state_i, cur_cnt_i}   = cur;
    wr_gnt_i = 0; wr_done_i = 0; wr_err_i = 0;
    prog_req_i = 1'b1;
    phase = 0; gnt_wait = 0; done_wait = 0; cyc = 0; ack_cyc = 0; post = 0;
    ack_seen = 0; ack_err = 0; done = 0; hold_addr = '0; hold_data = '0;

    while (!done && cyc < 3000) begin
      @(negedge clk_i);
      cyc++;
      if (rst_mid && phase == 2) begin
        rst_i = 1'b1;
        #1;
        check("rst_wr_req", 32'(wr_req_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ack", 32'(prog_ack_o), 32'd0);
        check("rst_addr", 32'(wr_addr_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        prog_req_i = 1'b0;
        wr_gnt_i = 0; wr_done_i = 0; wr_err_i = 0;
        return;
      end
      wr_gnt_i = 0; wr_done_i = 0; wr_err_i = 0;
      if (!ack_seen) begin
        if (phase == 0) begin
          if (wr_req_o) begin
            obs_addr.push_back(int'(wr_addr_o));
            obs_data.push_back(wr_data_o);
            hold_addr = wr_addr_o;
            hold_data = wr_data_o;
            phase = 1;
            gnt_wait = (gnt_fix >= 0) ? gnt_fix : int'($urandom_range(0, 3));
          end else if ($urandom_range(0, 5) == 0) begin
            wr_done_i = 1'b1;
            wr_err_i  = 1'($urandom);
          end
        end else if (phase == 1) begin
          check("req_hold", 32'(wr_req_o), 32'd1);
          check("addr_hold", 32'(wr_addr_o), 32'(hold_addr));
          check("data_hold", 32'(wr_data_o), 32'(hold_data));
        end else begin
          check("req_drop", 32'(wr_req_o), 32'd0);
          if (done_wait == 0) begin
            wr_done_i = 1'b1;
            wr_err_i  = (obs_addr.size() - 1 == fail_idx);
            phase = 0;
          end else begin
            done_wait--;
          end
        end
        if (phase == 1) begin
          if (gnt_wait == 0) begin
            wr_gnt_i = 1'b1;
            phase = 2;
            done_wait = $urandom_range(0, 2);
          end else begin
            gnt_wait--;
          end
        end
        if (prog_ack_o) begin
          ack_seen = 1'b1;
          ack_cyc  = cyc;
          ack_err  = prog_err_o;
          post     = $urandom_range(0, 3);
        end
      end else begin
        check("no_reack", 32'(prog_ack_o), 32'd0);
        if (post > 0) post--;
        else if (prog_req_i) prog_req_i = 1'b0;
        else begin
          check("idle_busy", 32'(busy_o), 32'd0);
          done = 1'b1;
        end
      end
    end

    check("ack_seen", 32'(ack_seen), 32'd1);
    check("txn_done", 32'(done), 32'd1);
    if (ack_seen) begin
      check("ack_err", 32'(ack_err), 32'(exp_err));
      if (exp_lat >= 0) check("ack_lat", 32'(ack_cyc), 32'(exp_lat));
    end
    check("n_writes", 32'(obs_addr.size()), 32'(exp_addr.size()));
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check("wr_addr", 32'(obs_addr[i]), 32'(exp_addr[i]));
      check("wr_data", 32'(obs_data[i]), 32'(exp_data[i]));
    end
    prog_req_i = 1'b0;
  endtask

  initial begin
    logic [TW-1:0] cur, tgt;
    int            nw, fidx, w;

    rst_i = 1'b1;
    prog_req_i = 0; prog_state_i = '0; prog_cnt_i = '0;
    cur_state_i = '0; cur_cnt_i = '0;
    wr_gnt_i = 0; wr_done_i = 0; wr_err_i = 0;
    repeat (2) @(negedge clk_i);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_wr_req", 32'(wr_req_o), 32'd0);
    check("reset_ack", 32'(prog_ack_o), 32'd0);
    check("reset_err", 32'(prog_err_o), 32'd0);
    check("reset_addr", 32'(wr_addr_o), 32'd0);
    check("reset_data", 32'(wr_data_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    cur = make_base(); tgt = bump(cur, 3);
    run_txn(cur, tgt, -1, -1, 1'b0);

    cur = make_base(); cur[NumLcCntWords*WW +: WW] = 16'h0001;
    tgt = bump(cur, 7); tgt[NumLcCntWords*WW +: WW] = 16'h0000;
    run_txn(cur, tgt, -1, -1, 1'b0);

    cur = make_base(); tgt = bump(bump(cur, 5), NumLcCntWords + 2);
    run_txn(cur, tgt, -1, -1, 1'b0);

    cur = make_base(); tgt = bump(bump(cur, 10), 30);
    run_txn(cur, tgt, 0, -1, 1'b0);

    cur = make_base(); tgt = bump(cur, 40);
    run_txn(cur, tgt, -1, 10, 1'b0);

    cur = make_base();
    run_txn(cur, cur, -1, -1, 1'b0);

    cur = make_base(); tgt = bump(bump(cur, 1), 2);
    run_txn(cur, tgt, -1, 0, 1'b1);
    cur = make_base(); tgt = bump(bump(cur, 0), NumLcWords - 1);
    run_txn(cur, tgt, -1, -1, 1'b0);

    for (int t = 0; t < 30; t++) begin
      cur = make_base();
      tgt = cur;
      nw  = $urandom_range(0, 4);
      for (int k = 0; k < nw; k++) tgt = bump(tgt, int'($urandom_range(0, NumLcWords - 1)));
      if ($urandom_range(0, 4) == 0) begin
        w = $urandom_range(0, NumLcWords - 1);
        cur[w*WW] = 1'b1;
        tgt[w*WW] = 1'b0;
      end
      fidx = ($urandom_range(0, 3) == 0 && nw > 0) ? int'($urandom_range(0, nw - 1)) : -1;
      run_txn(cur, tgt, fidx, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc_otp_prog_responder.md
Name: lc_otp_prog_responder

Overview:
- OTP-side responder to the life cycle controller's state/counter programming request.
- Accepts the next life cycle state vector and transition counter vector, checks that the update only sets bits relative to the currently stored value, then writes the changed 16-bit words to the OTP macro write port. Counter words are written first, then state words.
- Returns a single ack with an error flag.
- Sits between the lc_ctrl programming interface and the OTP life cycle partition macro port.

Parameters:
- LcStateWidth, 320, bits of the encoded life cycle state vector (20 words).
- LcCountWidth, 384, bits of the encoded transition counter vector (24 words).
- WordWidth, 16, OTP macro write granule.
- BaseAddr, 0, word address of counter word 0; state word 0 is at BaseAddr+LcCountWidth/WordWidth.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- prog_req_i  in  1  programming request, held until ack
- prog_state_i  in  LcStateWidth  target state vector, stable while prog_req_i high
- prog_cnt_i  in  LcCountWidth  target counter vector, stable while prog_req_i high
- prog_ack_o  out  1  one-cycle completion pulse
- prog_err_o  out  1  error qualifier, valid only with prog_ack_o
- cur_state_i  in  LcStateWidth  currently stored state vector
- cur_cnt_i  in  LcCountWidth  currently stored counter vector
- wr_req_o  out  1  macro word write request
- wr_addr_o  out  10  macro word address
- wr_data_o  out  WordWidth  macro word data
- wr_gnt_i  in  1  macro accepted request
- wr_done_i  in  1  macro write complete
- wr_err_i  in  1  macro write failed, qualified by wr_done_i
- busy_o  out  1  high in any state other than Idle

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: FSM=Idle; all outputs 0; word index 0; captured vectors 0.
- Idle:
  - On prog_req_i, capture prog_cnt_i/prog_state_i into a 704-bit target register (counter in low words).
  - Capture cur_cnt_i/cur_state_i the same way into the current register.
  - Go to Check.
- Check (1 cycle):
  - err_illegal = |(current & ~target), i.e. an attempt to clear an OTP bit.
  - If set: go to Ack with err=1; no writes are issued.
  - Otherwise: idx=0, go to Scan.
- Scan:
  - If word idx of target equals the same word of current, skip it: idx++ at one word per cycle.
  - If they differ, go to Write.
  - When idx reaches 44 (total words), go to Ack with err=0.
- Write:
  - wr_req_o=1, wr_addr_o=BaseAddr+idx, wr_data_o=target word idx.
  - Hold all three stable until wr_gnt_i, then drop wr_req_o and go to WaitDone.
  - wr_gnt_i in the same cycle as wr_req_o rises is valid.
- WaitDone:
  - On wr_done_i with wr_err_i=1: go to Ack with err=1 immediately; remaining words are not written.
  - On wr_done_i with wr_err_i=0: idx++, return to Scan.
- Ack:
  - prog_ack_o=1 and prog_err_o=err for exactly one cycle, then go to WaitReqLow.
- WaitReqLow:
  - Return to Idle when prog_req_i=0. A request that is still high does not retrigger.
- Invalid FSM encoding (sparse encoding, Hamming distance ≥3):
  - Go to a terminal Error state: busy_o=1, wr_req_o=0.
  - Any pending request is acked with err=1 and the FSM stays in Error until reset.
- Index arithmetic: idx is 6 bits; no wrap-around because the terminal check is idx==44.
- prog_req_i dropping before ack is a protocol violation; the FSM completes the operation regardless.
- wr_done_i while not in WaitDone is ignored.
- Reset mid-operation: immediate return to Idle, wr_req_o=0. A macro write already in flight is not tracked.
- Minimum latency, all words equal: 1 (capture) + 1 (Check) + 44 (Scan) cycles, then ack.

Decomposition:
- Shared package lc_ctrl_pkg holds:
  - NumLcCntWords=24, NumLcStateWords=20, NumLcWords=44 localparams.
  - The fsm encoding typedef lc_otp_prog_fsm_e with sparse values.
- One sub-module, lc_otp_word_sel: combinational word mux plus diff flag for index idx over the target and current registers.

Test Plan:
- Counter cur=LcCnt3, target=LcCnt4 (one counter word differs), state unchanged -> exactly one write at BaseAddr+3 with that word's data; ack with err=0.
- Target state clears a bit (cur word 0 = 16'h0001, target word 0 = 16'h0000) -> no wr_req_o; ack 2 cycles after req with err=1.
- Counter word 5 and state word 2 both differ -> writes in order: addr 5, then addr 26; ack err=0.
- Macro returns wr_err_i=1 on the first of two writes -> second write is never issued; ack err=1.
- Hold wr_gnt_i low for 10 cycles -> wr_req_o, wr_addr_o and wr_data_o stay stable; afterwards only one write is issued.
- Assert rst_i in WaitDone, then apply a new request -> outputs are 0 immediately; the new request restarts from idx 0.
